// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_subtractor cell.
// Optional signed overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_r;
    logic             accept;
    logic             last;
    logic             d_bit;
    logic             br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_bit),
        .bout (br_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic, start acceptance and last-bit detection.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand load, per-bit shift and result capture on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            bout_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            br      <= bus.bin;
            diff_sr <= '0;
            cnt     <= '0;
            bout_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            br      <= br_next;
            diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
            cnt     <= cnt + 1'b1;
            if (last) begin
                bout_r <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                // Borrow into the MSB is br; borrow out of it is br_next.
                ovf_r  <= br ^ br_next;
`endif
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_sr;
    assign bus.bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor, the inverse-direction companion to the team's ripple-carry adder datapath. It captures two operands and a borrow-in on a start handshake. It then resolves one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It reports difference and borrow-out with a one-cycle done pulse, trading WIDTH cycles of latency for one cell of logic.

## Interface
- WIDTH, 4, operand/result width in bits (legal: 2..32)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while bits are being resolved
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start.
  - SHIFT stays for WIDTH cycles, then goes to DONE.
  - DONE → SHIFT on start, else DONE → IDLE.
- Accepted start:
  - Load a and b into shift registers, load bin into the borrow register.
  - Clear the bit counter and clear the diff shift register.
- Each SHIFT cycle, on the LSB of a and b plus the current borrow:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the diff MSB.
  - Operands shift right and the counter increments.
- Leaving SHIFT: bout = final borrow. diff holds the full result, bit 0 in the LSB.
- diff, bout and ovf hold their values until the next accepted start. They are undefined-free: they keep their shifting contents during SHIFT.
- start while in SHIFT is ignored; no queueing.
- a, b and bin are don't-care except in the start-acceptance cycle.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, bout = 0, ovf = 0
  - counter = 0, borrow register = 0
- Reset mid-operation aborts immediately. No done is produced.

## Timing
- Start accepted at edge 0. busy = 1 from edge 0 through edge WIDTH−1.
- done = 1 and the result is valid after edge WIDTH. Latency: WIDTH+1 cycles from start-high cycle to done-high cycle.
- done is high for exactly one cycle; busy and done are never high together.
- Back-to-back: start high during the done cycle is accepted. busy rises the next cycle, giving a throughput of one result per WIDTH+1 cycles.
- busy and done are registered outputs with no combinational path from start.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port exists.
  - ovf = borrow into the MSB XOR borrow out of the MSB, captured in the last SHIFT cycle.
  - ovf is valid with done and held like diff.
- Not defined: no ovf port and no related logic. All other behaviour is identical.

## Structure
- Package serial_sub_pkg:
  - state enum type (IDLE, SHIFT, DONE)
  - counter-width constant function, $clog2(WIDTH)
- Sub-module full_subtractor: combinational (a, b, bin → diff, bout). Instantiated once; it is the serial counterpart of the full_adder cell.

## Test plan
- WIDTH=4, a=9, b=3, bin=0, start for 1 cycle → busy for 4 cycles, done on the 5th cycle with diff=6 and bout=0.
- a=3, b=9, bin=0 → diff=4'hA, bout=1. a=0, b=0, bin=1 → diff=4'hF, bout=1.
- With SERIAL_SUB_OVF_EN:
  - a=8, b=1 → diff=7, ovf=1.
  - a=7, b=1 → diff=6, ovf=0.
- start pulsed again in cycle 2 of SHIFT with different operands → ignored. The first result is unchanged and exactly one done pulse occurs.
- start held high across the done cycle with new operands (5, 5, 0) → second operation is accepted. diff=0, bout=0 arrives 5 cycles after the first done.
- rst asserted in the 2nd SHIFT cycle → busy, done, diff and bout go to 0 immediately; state is IDLE and no done appears. A subsequent start completes normally.
